// File: rtl/sub_bytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : sub_bytes_engine
//  Description : Sequential AES SubBytes unit. Substitutes every byte of a
//                NUM_BYTES-byte state word through LANES parallel S-boxes,
//                LANES bytes per clock, starting at byte 0. Valid/ready
//                handshakes on both sides; one state word in flight.
//                Optional inverse S-box for the decryption path, enabled
//                by defining the macro SBOX_INV_EN (adds the decrypt port).
//  Revision    : 1.0 - initial release
// ============================================================================
module sub_bytes_engine #(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
`ifdef SBOX_INV_EN
  ,
  input  logic                   decrypt
`endif
);

  localparam int c_beats = NUM_BYTES / LANES;
  localparam int c_cw    = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_cw-1:0] c_last = c_cw'(c_beats - 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_busy = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  // Forward S-box, entry x at index x.
  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SBOX_INV_EN
  // Inverse S-box, entry x at index x.
  localparam logic [0:255][7:0] c_inv_sbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
`endif

  // Reject lane counts outside the supported set or that do not tile the state.
  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
        (NUM_BYTES < LANES) || (NUM_BYTES % LANES != 0)) begin : g_param_check
      $error("sub_bytes_engine: illegal NUM_BYTES/LANES combination");
    end
  endgenerate

  logic [1:0]             r_state;
  logic [c_cw-1:0]        r_cnt;
  logic [8*NUM_BYTES-1:0] r_work;
  logic [8*NUM_BYTES-1:0] r_out_data;
  logic                   r_out_valid;
`ifdef SBOX_INV_EN
  logic                   r_mode;
`endif

  logic [7:0]             w_lane_in  [LANES];
  logic [7:0]             w_lane_out [LANES];
  logic [8*NUM_BYTES-1:0] w_work_next;

  // Select the bytes of the current beat for each lane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_lane_in[l] = 8'h00;
      for (int b = 0; b < c_beats; b++) begin
        if (r_cnt == c_cw'(b)) begin
          w_lane_in[l] = r_work[(b*LANES+l)*8 +: 8];
        end
      end
    end
  end

  // One S-box lookup per lane; mode is the value latched at acceptance.
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
`ifdef SBOX_INV_EN
      assign w_lane_out[l] = r_mode ? c_inv_sbox[w_lane_in[l]] : c_sbox[w_lane_in[l]];
`else
      assign w_lane_out[l] = c_sbox[w_lane_in[l]];
`endif
    end
  endgenerate

  // Write the substituted bytes back in place within the working word.
  always_comb begin
    w_work_next = r_work;
    for (int b = 0; b < c_beats; b++) begin
      if (r_cnt == c_cw'(b)) begin
        for (int l = 0; l < LANES; l++) begin
          w_work_next[(b*LANES+l)*8 +: 8] = w_lane_out[l];
        end
      end
    end
  end

  // Control FSM, beat counter, working register and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= c_idle;
      r_cnt       <= '0;
      r_work      <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef SBOX_INV_EN
      r_mode      <= 1'b0;
`endif
    end else begin
      case (r_state)
        c_idle: begin
          if (in_valid) begin
            r_work  <= in_data;
            r_cnt   <= '0;
            r_state <= c_busy;
`ifdef SBOX_INV_EN
            r_mode  <= decrypt;
`endif
          end
        end
        c_busy: begin
          r_work <= w_work_next;
          if (r_cnt == c_last) begin
            // Final beat: publish the full result; counter stays on the last beat.
            r_out_data  <= w_work_next;
            r_out_valid <= 1'b1;
            r_state     <= c_done;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        c_done: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= c_idle;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign in_ready  = (r_state == c_idle);
  assign busy      = (r_state == c_busy);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sub_bytes_engine
//  Description : Directed self-checking bench for sub_bytes_engine. Three
//                instances (LANES = 4, 1, 16) share the input side so that
//                results and latencies of each lane count are compared
//                against hand-computed AES S-box values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sub_bytes_engine;

  localparam logic [127:0] c_vec3 = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] c_exp3 = 128'h1628c14beaaceec4f533fc1bc3938263;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [127:0] in_data;
  logic         out_ready;
  logic         decrypt;

  logic         ir4, ov4, bs4;
  logic [127:0] od4;
  logic         ir1, ov1, bs1;
  logic [127:0] od1;
  logic         ir16, ov16, bs16;
  logic [127:0] od16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sub_bytes_engine #(.NUM_BYTES(16), .LANES(4)) u_l4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir4), .in_data(in_data),
    .out_valid(ov4), .out_ready(out_ready), .out_data(od4), .busy(bs4)
`ifdef SBOX_INV_EN
    , .decrypt(decrypt)
`endif
  );

  sub_bytes_engine #(.NUM_BYTES(16), .LANES(1)) u_l1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .busy(bs1)
`ifdef SBOX_INV_EN
    , .decrypt(decrypt)
`endif
  );

  sub_bytes_engine #(.NUM_BYTES(16), .LANES(16)) u_l16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir16), .in_data(in_data),
    .out_valid(ov16), .out_ready(out_ready), .out_data(od16), .busy(bs16)
`ifdef SBOX_INV_EN
    , .decrypt(decrypt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one state word to all instances and check result and latency.
  // With stall set, out_ready is held low and garbage in_valid/in_data/decrypt
  // are driven while the engines work and hold their results.
  task automatic run_op(input logic [127:0] d, input logic dec,
                        input logic [127:0] exp, input bit stall);
    int           lat4  = 0;
    int           lat1  = 0;
    int           lat16 = 0;
    int           rdy4  = 0;
    logic [127:0] held;
    bit           stable;
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = d;
    decrypt   = dec;
    out_ready = !stall;
    @(posedge clk); #1;
    if (stall) begin
      in_data = ~d;
      decrypt = ~dec;
    end else begin
      in_valid = 1'b0;
    end
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(posedge clk); #1;
      if (ov4  && lat4  == 0) lat4  = cyc;
      if (ov1  && lat1  == 0) lat1  = cyc;
      if (ov16 && lat16 == 0) lat16 = cyc;
      if (!stall && ir4 && rdy4 == 0) rdy4 = cyc;
      if (stall) begin
        in_data = {$urandom, $urandom, $urandom, $urandom};
        decrypt = ~decrypt;
      end
      if (lat4 != 0 && lat1 != 0 && lat16 != 0 && (stall || rdy4 != 0)) break;
    end
    chk("latency_l4",  lat4,  4);
    chk("latency_l1",  lat1,  16);
    chk("latency_l16", lat16, 1);
    chk("data_l4",  od4,  exp);
    chk("data_l1",  od1,  exp);
    chk("data_l16", od16, exp);
    if (!stall) begin
      chk("in_ready_back_l4", rdy4, 5);
      repeat (2) @(posedge clk);
    end else begin
      held   = od4;
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        if (!ov4 || od4 !== held || ir4 || !ov1 || !ov16) stable = 1'b0;
        in_data = {$urandom, $urandom, $urandom, $urandom};
      end
      chk("stall_hold", stable, 1);
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("ack_valid_clear", {ov4, ov1, ov16}, 3'b000);
      chk("ack_in_ready",    {ir4, ir1, ir16}, 3'b111);
      chk("ack_data_held",   od4, exp);
    end
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    decrypt   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {ov4, ov1, ov16}, 3'b000);
    chk("rst_in_ready",  {ir4, ir1, ir16}, 3'b111);
    chk("rst_busy",      {bs4, bs1, bs16}, 3'b000);
    chk("rst_out_data",  od4 | od1 | od16, 128'h0);
    @(negedge clk);
    rst = 1'b0;

    // All-zero state.
    run_op(128'h0, 1'b0, {16{8'h63}}, 1'b0);
    // Ascending byte pattern with a stalled consumer.
    run_op(c_vec3, 1'b0, c_exp3, 1'b1);
    // Uniform 0x53 pattern.
    run_op({16{8'h53}}, 1'b0, {16{8'hed}}, 1'b0);

    // Asynchronous reset pulse between edges clears the held result at once.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_data",     od4 | od1 | od16, 128'h0);
    chk("async_rst_valid",    {ov4, ov1, ov16}, 3'b000);
    chk("async_rst_in_ready", {ir4, ir1, ir16}, 3'b111);
    chk("async_rst_busy",     {bs4, bs1, bs16}, 3'b000);
    rst = 1'b0;

    // Reset during the second BUSY cycle aborts the operation.
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = c_vec3;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", {bs4, bs1}, 2'b00);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ov4 || ov1 || ov16) seen = 1'b1;
    end
    chk("abort_no_valid", seen, 1'b0);
    run_op(128'h0, 1'b0, {16{8'h63}}, 1'b0);

`ifdef SBOX_INV_EN
    // Inverse path; decrypt toggles while busy must not matter.
    run_op(c_exp3, 1'b1, c_vec3, 1'b1);
    run_op({16{8'h63}}, 1'b1, 128'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
Sequential, parametrised AES SubBytes unit that substitutes every byte of an NUM_BYTES-byte state through LANES parallel S-box instances, LANES bytes per clock. It succeeds the single-byte combinational SBox. It sits between AddRoundKey and ShiftRows in the round datapath. It uses valid/ready handshakes on input and output. It optionally supports the inverse S-box for the decryption path.

Parameters:
NUM_BYTES, 16, bytes per state word; must be a multiple of LANES.
LANES, 4, S-box instances used in parallel; legal values 1, 2, 4, 8, 16. Illegal combinations abort elaboration.

Ports:
clk  input  1  single clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/decrypt valid
in_ready  output  1  engine can accept a state word
in_data  input  8*NUM_BYTES  state word; byte i = in_data[8i+7:8i]
out_valid  output  1  out_data holds a completed result
out_ready  input  1  consumer accepts out_data
out_data  output  8*NUM_BYTES  substituted state; byte i at [8i+7:8i]
busy  output  1  high while in BUSY state
decrypt  input  1  present only with SBOX_INV_EN; 1 = inverse S-box

Behaviour:
- Reset (async, rst=1): state=IDLE, beat counter=0, out_data=0, out_valid=0, busy=0, in_ready=1. The working register and latched mode are cleared. A reset asserted mid-operation aborts it with no partial output.
- FSM states:
  - IDLE: in_ready=1. If in_valid=1 at a clock edge, latch in_data into the working register, latch mode, set counter=0, and go to BUSY.
  - BUSY: in_ready=0, busy=1. Each edge substitutes bytes counter*LANES .. counter*LANES+LANES-1 in place, then increments the counter. On the edge where counter == NUM_BYTES/LANES-1, that final beat completes, out_data gets the full result, out_valid=1, and the FSM goes to DONE.
  - DONE: out_valid=1, in_ready=0. If out_ready=1 at an edge, clear out_valid and go to IDLE. out_data holds its value until the next result is written.
- Latency: out_valid is first high after exactly NUM_BYTES/LANES edges following the accepting edge. With defaults that is 4 cycles.
- Throughput: at most one state every NUM_BYTES/LANES+2 cycles. No overlap: in_ready stays low in BUSY and DONE.
- Byte order: beats proceed from byte 0 (LSB) upward. The counter is $clog2(NUM_BYTES/LANES) bits wide, minimum 1, and never wraps past the last beat.
- in_data and decrypt changes after the accepting edge are ignored. in_valid in BUSY/DONE is ignored (not queued).
- Mode is latched at acceptance and held constant for all beats of that state.
- LANES == NUM_BYTES: a single BUSY beat, so out_valid rises one edge after acceptance.
- out_valid deasserts only through an out_ready handshake or reset.

Optional Feature:
Macro: SBOX_INV_EN.
- Defined: the decrypt port exists and each lane also holds the FIPS-197 inverse S-box table. decrypt=1 (latched at acceptance) selects the inverse table; decrypt=0 selects the forward table.
- Undefined: no decrypt port, forward table only, and the inverse table is not synthesised.

Test Plan:
1. rst pulsed high asynchronously between edges -> outputs go immediately to out_valid=0, in_ready=1, busy=0, out_data=0.
2. Defaults; in_data=128'h0, held one cycle with in_valid=1, out_ready=1 -> out_valid high 4 edges after acceptance; out_data=128'h63636363636363636363636363636363; in_ready=1 one cycle later.
3. in_data=128'hffeeddccbbaa99887766554433221100 -> out_data=128'h1628c14beaaceec4f533fc1bc3938263. out_ready=0 for 5 cycles: out_valid and out_data held; in_valid=1 with different data is ignored throughout.
4. LANES=1 and LANES=16 builds with the test 3 vector -> identical out_data; latencies of 16 and 1 edges respectively.
5. rst asserted on the 2nd BUSY cycle, then released, then test 2 stimulus -> no out_valid from the aborted op; the new result is correct (all 0x63).
6. SBOX_INV_EN defined, decrypt=1, in_data=128'h1628c14beaaceec4f533fc1bc3938263 -> out_data=128'hffeeddccbbaa99887766554433221100. Toggling decrypt during BUSY has no effect.
